// File: rtl/spi_byte_rx_if.sv
// Receive-side word stream of spi_byte_rx: word, D/C flag, valid/ready handshake.
interface spi_byte_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_dc;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output rx_data,
    output rx_dc,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_dc,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: SPI mode-0 target deserializer with ILI9341 D/C capture.
// Bytes arrive MSB first on spi_mosi, sampled on synchronized SCLK rise, and are
// handed out through spi_byte_rx_if (valid/ready). Optional MISO transmit path is
// enabled by defining SPI_BYTE_RX_MISO_EN; the default build is receive-only.
module spi_byte_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  input  logic              spi_dc,
  spi_byte_rx_if.master     rx,
  output logic              rx_overrun,
  output logic              rx_frame_err,
  output logic              busy
`ifdef SPI_BYTE_RX_MISO_EN
  ,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              spi_miso
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_dc_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic w_sclk_s, w_cs_s, w_mosi_s, w_dc_s;
  logic w_sclk_rise, w_cs_rise, w_cs_fall;

  state_t r_state, w_state_nxt;
  logic   w_clr_cnt, w_shift_en, w_frame_err;

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_done;
  logic              r_done_dc;

  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_dc;
  logic              r_rx_valid;
  logic              r_overrun;
  logic              r_frame_err;
  logic              r_busy;
  logic              w_hs, w_load;

`ifdef SPI_BYTE_RX_MISO_EN
  logic              w_sclk_fall;
  logic              w_tx_reload, w_tx_shift_en;
  logic [DATA_W-1:0] r_tx_shadow;
  logic              r_shadow_full;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] w_tx_shift_nxt;
  logic              r_miso;
`endif

  // Input synchronizers, reset to the bus idle levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_dc_sync   <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], spi_dc};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_dc_s      = r_dc_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
`ifdef SPI_BYTE_RX_MISO_EN
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state: frame opens on CS_N fall, closes on CS_N rise.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_cs_fall) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_cs_rise) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM controls: CS_N rise takes priority over a coincident SCLK rise.
  always_comb begin
    w_clr_cnt   = 1'b0;
    w_shift_en  = 1'b0;
    w_frame_err = 1'b0;
`ifdef SPI_BYTE_RX_MISO_EN
    w_tx_reload   = 1'b0;
    w_tx_shift_en = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_clr_cnt = 1'b1;
`ifdef SPI_BYTE_RX_MISO_EN
          w_tx_reload = 1'b1;
`endif
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_clr_cnt   = 1'b1;
          w_frame_err = (r_cnt != '0);
        end else if (w_sclk_rise) begin
          w_shift_en = 1'b1;
        end
`ifdef SPI_BYTE_RX_MISO_EN
        // After the last bit of a word (count wrapped) the fall presents the next word.
        else if (w_sclk_fall) begin
          if (r_cnt == '0) w_tx_reload   = 1'b1;
          else             w_tx_shift_en = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // Receive shift register and bit counter; r_done flags a completed word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
      r_done_dc <= 1'b0;
    end else begin
      r_done <= w_shift_en && (r_cnt == CNT_LAST);
      if (w_clr_cnt) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[DATA_W-2:0], w_mosi_s};
        r_cnt   <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) r_done_dc <= w_dc_s;
      end
    end
  end

  assign w_hs   = r_rx_valid & rx.rx_ready;
  assign w_load = r_done & (~r_rx_valid | rx.rx_ready);

  // Output port: load on free slot, otherwise drop and flag overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data   <= '0;
      r_rx_dc     <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_load) begin
        r_rx_data  <= r_shift;
        r_rx_dc    <= r_done_dc;
        r_rx_valid <= 1'b1;
      end else if (w_hs) begin
        r_rx_valid <= 1'b0;
      end
      if (r_done && !w_load) r_overrun <= 1'b1;
      else if (w_hs)         r_overrun <= 1'b0;
      r_frame_err <= w_frame_err;
      r_busy      <= (w_state_nxt == ST_SHIFT);
    end
  end

  assign rx.rx_data   = r_rx_data;
  assign rx.rx_dc     = r_rx_dc;
  assign rx.rx_valid  = r_rx_valid;
  assign rx_overrun   = r_overrun;
  assign rx_frame_err = r_frame_err;
  assign busy         = r_busy;

`ifdef SPI_BYTE_RX_MISO_EN
  // Next transmit shift value: reload from shadow (0 if empty) or shift left.
  always_comb begin
    w_tx_shift_nxt = r_tx_shift;
    if (w_tx_reload)        w_tx_shift_nxt = r_shadow_full ? r_tx_shadow : '0;
    else if (w_tx_shift_en) w_tx_shift_nxt = {r_tx_shift[DATA_W-2:0], 1'b0};
  end

  // Transmit shadow, shift register and registered MISO pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_shadow   <= '0;
      r_shadow_full <= 1'b0;
      r_tx_shift    <= '0;
      r_miso        <= 1'b0;
    end else begin
      r_tx_shift <= w_tx_shift_nxt;
      r_miso     <= (w_state_nxt == ST_SHIFT) ? w_tx_shift_nxt[DATA_W-1] : 1'b0;
      if (w_tx_reload) r_shadow_full <= 1'b0;
      if (tx_load) begin
        r_tx_shadow   <= tx_data;
        r_shadow_full <= 1'b1;
      end
    end
  end

  assign spi_miso = r_miso;
`endif

endmodule

// File: tb/tb_spi_byte_rx.sv
// Self-checking bench for spi_byte_rx: directed scenarios plus a randomized
// multi-word stream compared against a queue-based reference model.
module tb_spi_byte_rx;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned HALF   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_dc   = 1'b0;
  logic rx_overrun, rx_frame_err, busy;
`ifdef SPI_BYTE_RX_MISO_EN
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_load = 1'b0;
  logic              spi_miso;
`endif

  spi_byte_rx_if #(.DATA_W(DATA_W)) rx_if ();

  spi_byte_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_dc       (spi_dc),
    .rx           (rx_if),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .busy         (busy)
`ifdef SPI_BYTE_RX_MISO_EN
    ,
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .spi_miso     (spi_miso)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DATA_W:0] got[$];
  int fe_cycles = 0;
  bit rand_ready = 1'b0;

  // Record accepted words {dc, data} and frame-error cycles.
  always @(negedge clk) begin
    if (rx_if.rx_valid && rx_if.rx_ready) got.push_back({rx_if.rx_dc, rx_if.rx_data});
    if (rx_frame_err) fe_cycles++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic dc);
    spi_mosi = b;
    spi_dc   = dc;
    if (rand_ready) rx_if.rx_ready = ($urandom_range(3) != 0);
    wait_clk(HALF);
    spi_sclk = 1'b1;
    wait_clk(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input logic dc);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      send_bit(w[i], dc);
      if (rand_ready && i == 3) rx_if.rx_ready = 1'b1;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(HALF + 2);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(HALF + 4);
  endtask

  task automatic check_word(input string name, input int idx, input logic [DATA_W:0] exp);
    checks++;
    if (got.size() <= idx) begin
      errors++;
      $display("FAIL %s: word %0d missing (got %0d words), required %h", name, idx, got.size(), exp);
    end else if (got[idx] !== exp) begin
      errors++;
      $display("FAIL %s: word %0d got {dc,data}=%h required %h", name, idx, got[idx], exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({rx_if.rx_valid, rx_if.rx_data, rx_if.rx_dc, rx_overrun, rx_frame_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h dc=%b ovr=%b fe=%b busy=%b, required all 0",
               rx_if.rx_valid, rx_if.rx_data, rx_if.rx_dc, rx_overrun, rx_frame_err, busy);
    end
  endtask

  // 0x2A, DC=0, with last-bit latency measurement.
  task automatic test_single();
    int k;
    got.delete();
    fe_cycles = 0;
    rx_if.rx_ready = 1'b1;
    cs_low();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_frame: got %b required 1", busy);
    end
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h2A >> i), 1'b0);
    spi_mosi = 1'b0;
    wait_clk(HALF);
    spi_sclk = 1'b1;
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (rx_if.rx_valid && k == 0) k = c;
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL latency: rx_valid after %0d clk, required 4", k);
    end
    spi_sclk = 1'b0;
    cs_high();
    checks++;
    if (got.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d words required 1", got.size());
    end
    check_word("single", 0, {1'b0, 8'h2A});
    checks++;
    if (fe_cycles != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_status: frame_err cycles %0d busy %b, required 0 0", fe_cycles, busy);
    end
  endtask

  task automatic test_back_to_back();
    got.delete();
    cs_low();
    send_word(8'hF8, 1'b1);
    send_word(8'h1F, 1'b1);
    cs_high();
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d words required 2", got.size());
    end
    check_word("b2b", 0, {1'b1, 8'hF8});
    check_word("b2b", 1, {1'b1, 8'h1F});
  endtask

  task automatic test_overrun();
    got.delete();
    rx_if.rx_ready = 1'b0;
    cs_low();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    cs_high();
    checks++;
    if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h11 || rx_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold: valid=%b data=%h ovr=%b, required 1 11 1",
               rx_if.rx_valid, rx_if.rx_data, rx_overrun);
    end
    rx_if.rx_ready = 1'b1;
    wait_clk(1);
    checks++;
    if (rx_if.rx_valid !== 1'b0 || rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: valid=%b ovr=%b, required 0 0", rx_if.rx_valid, rx_overrun);
    end
    wait_clk(2);
    checks++;
    if (got.size() != 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d words required 1", got.size());
    end
    check_word("overrun", 0, {1'b0, 8'h11});
  endtask

  task automatic test_frame_err();
    got.delete();
    fe_cycles = 0;
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    cs_high();
    checks++;
    if (fe_cycles != 1 || got.size() != 0) begin
      errors++;
      $display("FAIL frame_err: pulse cycles %0d words %0d, required 1 0", fe_cycles, got.size());
    end
    cs_low();
    send_word(8'hA5, 1'b0);
    cs_high();
    checks++;
    if (got.size() != 1) begin
      errors++;
      $display("FAIL after_err_count: got %0d words required 1", got.size());
    end
    check_word("after_err", 0, {1'b0, 8'hA5});
  endtask

  task automatic test_reset_mid();
    got.delete();
    rx_if.rx_ready = 1'b0;
    cs_low();
    send_word(8'h77, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
    rst = 1'b0;
    #1;
    checks++;
    if ({rx_if.rx_valid, rx_if.rx_data, rx_if.rx_dc, rx_overrun, rx_frame_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b data=%h dc=%b ovr=%b fe=%b busy=%b, required all 0",
               rx_if.rx_valid, rx_if.rx_data, rx_if.rx_dc, rx_overrun, rx_frame_err, busy);
    end
    spi_cs_n = 1'b1;
    spi_dc   = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    rx_if.rx_ready = 1'b1;
    wait_clk(3);
    cs_low();
    send_word(8'h3C, 1'b0);
    cs_high();
    checks++;
    if (got.size() != 1) begin
      errors++;
      $display("FAIL post_reset_count: got %0d words required 1", got.size());
    end
    check_word("post_reset", 0, {1'b0, 8'h3C});
  endtask

  // Random frames/words/DC with a stalling consumer; model is an ordered queue.
  task automatic test_random();
    logic [DATA_W:0] exp_q[$];
    logic [DATA_W-1:0] w;
    logic d;
    int nw;
    got.delete();
    fe_cycles = 0;
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      nw = $urandom_range(1, 3);
      cs_low();
      for (int j = 0; j < nw; j++) begin
        w = DATA_W'($urandom);
        d = 1'($urandom);
        exp_q.push_back({d, w});
        send_word(w, d);
      end
      rx_if.rx_ready = 1'b1;
      cs_high();
    end
    rand_ready = 1'b0;
    rx_if.rx_ready = 1'b1;
    wait_clk(4);
    checks++;
    if (got.size() != exp_q.size() || rx_overrun !== 1'b0 || fe_cycles != 0) begin
      errors++;
      $display("FAIL random_status: words %0d ovr %b fe %0d, required %0d 0 0",
               got.size(), rx_overrun, fe_cycles, exp_q.size());
    end
    foreach (exp_q[i]) check_word("random", i, exp_q[i]);
  endtask

`ifdef SPI_BYTE_RX_MISO_EN
  task automatic test_miso();
    logic [DATA_W-1:0] tx;
    tx = 8'hD3;
    got.delete();
    checks++;
    if (spi_miso !== 1'b0) begin
      errors++;
      $display("FAIL miso_idle: got %b required 0", spi_miso);
    end
    tx_data = tx;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
    cs_low();
    for (int i = DATA_W - 1; i >= 0; i--) begin
      spi_mosi = 1'b0;
      spi_dc   = 1'b0;
      wait_clk(HALF);
      checks++;
      if (spi_miso !== tx[i]) begin
        errors++;
        $display("FAIL miso_bit%0d: got %b required %b", i, spi_miso, tx[i]);
      end
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
    cs_high();
    check_word("miso_rx", 0, {1'b0, 8'h00});
    checks++;
    if (spi_miso !== 1'b0) begin
      errors++;
      $display("FAIL miso_after: got %b required 0", spi_miso);
    end
  endtask
`endif

  initial begin
    rx_if.rx_ready = 1'b0;
    wait_clk(3);
    test_reset();
    rst = 1'b1;
    wait_clk(3);
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    test_random();
`ifdef SPI_BYTE_RX_MISO_EN
    test_miso();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
